des_final_perm_serializer: RTL and testbench
============================================

// Module: des_final_perm_serializer
// PURPOSE
// Output stage of the DES datapath; the counterpart to the input-side initial permutation.
// - Accepts the round-16 halves L16/R16.
// - Applies the final swap and the inverse initial permutation (IP^-1).
// - Registers the 64-bit ciphertext.
// - Streams the ciphertext as 8 bytes over a valid/ready interface.
// PARAMETERS
// LSB_BYTE_FIRST  0  0: first byte sent = ct[63:56]; 1: first byte sent = ct[7:0]
// CT_HOLD         1  1: ct_o holds the last block; 0: ct_o reads 0 while IDLE
// PORTS
// clk        in   1   clock, rising edge
// rst_n      in   1   reset, asynchronous, active-low
// in_valid   in   1   L16/R16 valid
// in_ready   out  1   block can accept a new L16/R16 (high only in IDLE, no flush)
// l16_i      in   32  round-16 left half; DES bit n at index 32-n
// r16_i      in   32  round-16 right half; DES bit n at index 32-n
// flush_i    in   1   synchronous abort of the current block
// ct_o       out  64  ciphertext; DES bit n at index 64-n
// ct_valid   out  1   one-cycle pulse when ct_o updates
// out_valid  out  1   byte-stream valid
// out_ready  in   1   byte-stream ready
// out_data   out  8   ciphertext byte
// out_last   out  1   high with the 8th byte
// BEHAVIOUR
// - Clock and reset: single clock clk; rst_n is asynchronous and active-low.
// - Reset state: FSM=IDLE, byte counter=0, ct_o=0, ct_valid=0, out_valid=0, out_data=0, out_last=0.
//   in_ready=1 once reset deasserts.
// - Preoutput: pre = {r16_i, l16_i}, so DES bits 1..32 of pre are R16.
// - Final permutation: DES bit j (1..64) of ct = pre bit FP[j].
//   - Let i=j-1, r=i/8, c=i%8.
//   - FP = (c even ? 40+4c : 4+4c) - r.
//   - This is the standard IP^-1 table: 40 8 48 16 56 24 64 32 / 39 7 ... / 33 1 41 9 49 17 57 25.
//   - The permutation is pure wiring, with no arithmetic.
// - FSM states:
//   - IDLE: in_ready=1. On in_valid at edge T: ct_o<=FP(pre), ct_valid=1 for cycle T+1, count<=0, go to SEND.
//   - SEND: out_valid=1. out_data = byte[count]. Byte k is ct[63-8k -: 8], or ct[8k +: 8] if LSB_BYTE_FIRST.
//     - A transfer happens on out_valid & out_ready; it increments count (3-bit).
//     - out_last=1 when count==7.
//     - A transfer with out_last returns to IDLE and count wraps to 0.
// - Latency: first byte is presented in cycle T+1. Minimum 9 cycles per block, because in_ready is low throughout SEND.
// - Output stability: out_data and out_last are stable while out_valid & !out_ready. No byte is skipped or repeated.
// - Inputs outside IDLE: in_valid is ignored while in SEND, and l16_i/r16_i are sampled only on acceptance.
// - Flush:
//   - flush_i has priority over acceptance and transfer; in_ready=0 while flush_i=1.
//   - Next cycle: FSM=IDLE, count=0, out_valid=0, out_last=0.
//   - ct_o is unchanged (or reads 0 if CT_HOLD=0). No ct_valid pulse.
// - Reset mid-stream: immediate abort to the reset state; remaining bytes are never sent.
// - CT_HOLD=0: ct_o reads 0 while in IDLE and holds the ciphertext during SEND.
// TESTING
// - Known-answer: l16_i=32'h43423234, r16_i=32'h0A4CD995
//   -> ct_o=64'h85E813540F0AB405, ct_valid 1 cycle;
//   -> bytes 85,E8,13,54,0F,0A,B4,05, out_last only on 05.
// - Single-bit mapping:
//   - l16_i=32'h80000000, r16_i=0 -> ct_o=64'h0000000000000080.
//   - l16_i=0, r16_i=32'h80000000 -> ct_o=64'h0000000000000040.
// - Backpressure: KAT vector with out_ready toggled 1,0,0,1,... -> same 8 bytes in order;
//   out_data stable during stalls; in_ready=0 until the cycle after the out_last transfer.
// - LSB_BYTE_FIRST=1: KAT vector -> bytes 05,B4,0A,0F,54,13,E8,85.
// - Flush after 3 bytes (85,E8,13) -> out_valid=0 next cycle, in_ready=1;
//   a new all-ones block -> ct_o=64'hFFFFFFFFFFFFFFFF, 8 bytes of FF.
// - rst_n low mid-SEND (async, between edges) -> all outputs 0 immediately;
//   after release in_ready=1 and no stale byte is emitted.

Source files
------------

// File: rtl/des_final_perm_serializer.sv
// rtl/des_final_perm_serializer.sv - DES output stage: final swap, IP^-1, ciphertext register, byte streamer
module des_final_perm_serializer #(
  parameter bit LSB_BYTE_FIRST = 1'b0,
  parameter bit CT_HOLD        = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] l16_i,
  input  logic [31:0] r16_i,
  input  logic        flush_i,
  output logic [63:0] ct_o,
  output logic        ct_valid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last
);

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [63:0] ct_q, ct_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        ct_valid_q, ct_valid_d;
  logic [63:0] pre;
  logic [63:0] fp;
  logic        accept;
  logic        xfer;
  logic [5:0]  byte_idx;

  // Final swap: R16 occupies DES bits 1..32 of the preoutput.
  assign pre = {r16_i, l16_i};

  // IP^-1 as fixed wiring; vector index 64-n carries DES bit n.
  for (genvar j = 0; j < 64; j++) begin : g_fp
    localparam int ROW = j / 8;
    localparam int COL = j % 8;
    localparam int SRC = ((COL % 2) == 0) ? (40 + 4 * COL - ROW) : (4 + 4 * COL - ROW);
    assign fp[63 - j] = pre[64 - SRC];
  end

  assign accept = (state_q == S_IDLE) && in_valid && !flush_i;
  assign xfer   = (state_q == S_SEND) && out_ready && !flush_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) state_d = S_SEND;
        S_SEND: if (out_ready && (cnt_q == 3'd7)) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ct_d       = ct_q;
    cnt_d      = cnt_q;
    ct_valid_d = accept;
    if (flush_i) begin
      cnt_d = 3'd0;
    end else if (accept) begin
      ct_d  = fp;
      cnt_d = 3'd0;
    end else if (xfer) begin
      cnt_d = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ct_q       <= 64'd0;
      cnt_q      <= 3'd0;
      ct_valid_q <= 1'b0;
    end else begin
      ct_q       <= ct_d;
      cnt_q      <= cnt_d;
      ct_valid_q <= ct_valid_d;
    end
  end

  assign byte_idx = LSB_BYTE_FIRST ? {cnt_q, 3'b000} : {~cnt_q, 3'b000};

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = 8'd0;
    ct_o      = ct_q;
    ct_valid  = ct_valid_q;
    case (state_q)
      S_IDLE: begin
        in_ready = rst_n && !flush_i;
        if (!CT_HOLD) ct_o = 64'd0;
      end
      S_SEND: begin
        out_valid = 1'b1;
        out_last  = (cnt_q == 3'd7);
        out_data  = ct_q[byte_idx +: 8];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_des_final_perm_serializer.sv
// tb/tb_des_final_perm_serializer.sv - randomized self-checking bench against a table-driven IP^-1 model
module tb_des_final_perm_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] l16_i, r16_i;
  logic        flush_i;
  logic        out_ready;

  logic        in_ready, ct_valid, out_valid, out_last;
  logic [63:0] ct_o;
  logic [7:0]  out_data;
  logic        l_in_ready, l_ct_valid, l_out_valid, l_out_last;
  logic [63:0] l_ct_o;
  logic [7:0]  l_out_data;

  int checks   = 0;
  int failures = 0;
  int cycles   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycles++;

  des_final_perm_serializer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .l16_i(l16_i), .r16_i(r16_i), .flush_i(flush_i), .ct_o(ct_o), .ct_valid(ct_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  des_final_perm_serializer #(.LSB_BYTE_FIRST(1'b1), .CT_HOLD(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(l_in_ready),
    .l16_i(l16_i), .r16_i(r16_i), .flush_i(flush_i), .ct_o(l_ct_o), .ct_valid(l_ct_valid),
    .out_valid(l_out_valid), .out_ready(out_ready), .out_data(l_out_data), .out_last(l_out_last)
  );

  // Standard DES IP^-1 table, DES bit numbering 1..64.
  int fp_tab [64] = '{40, 8, 48, 16, 56, 24, 64, 32,
                      39, 7, 47, 15, 55, 23, 63, 31,
                      38, 6, 46, 14, 54, 22, 62, 30,
                      37, 5, 45, 13, 53, 21, 61, 29,
                      36, 4, 44, 12, 52, 20, 60, 28,
                      35, 3, 43, 11, 51, 19, 59, 27,
                      34, 2, 42, 10, 50, 18, 58, 26,
                      33, 1, 41,  9, 49, 17, 57, 25};

  logic [63:0] kat_ct = 64'h85E813540F0AB405;
  logic [7:0]  kat_b [8] = '{8'h85, 8'hE8, 8'h13, 8'h54, 8'h0F, 8'h0A, 8'hB4, 8'h05};

  function automatic logic [63:0] fp_model(input logic [31:0] l, input logic [31:0] r);
    logic [63:0] pre;
    logic [63:0] ct;
    pre = {r, l};
    for (int j = 1; j <= 64; j++) ct[64 - j] = pre[64 - fp_tab[j - 1]];
    return ct;
  endfunction

  function automatic logic [7:0] msb_byte(input logic [63:0] ct, input int k);
    logic [63:0] s;
    s = ct >> (56 - 8 * k);
    return s[7:0];
  endfunction

  function automatic logic [7:0] lsb_byte(input logic [63:0] ct, input int k);
    logic [63:0] s;
    s = ct >> (8 * k);
    return s[7:0];
  endfunction

  // Results gathered by drive_block, judged by each test.
  logic [7:0]  got_b [8];
  logic [7:0]  got_l [8];
  logic        got_last [8];
  logic        got_last_l [8];
  logic [63:0] got_ct, got_ct_l;
  int          got_n, stall_bad, ct_pulses, l_pulses, in_ready_send, timeout_f, acc_cyc;
  logic        acc_ready;

  // Called between edges; returns on the negedge after the last requested transfer.
  task automatic drive_block(input logic [31:0] l, input logic [31:0] r, input int mode,
                             input int stop_after, input bit hold, input logic [31:0] nl,
                             input logic [31:0] nr);
    int cyc;
    logic prev_stall;
    logic [7:0] prev_d;
    logic prev_last;
    got_n = 0; stall_bad = 0; ct_pulses = 0; l_pulses = 0; in_ready_send = 0; timeout_f = 0;
    in_valid = 1'b1; l16_i = l; r16_i = r; out_ready = 1'b0;
    #1 acc_ready = in_ready;
    @(negedge clk);
    if (hold) begin
      in_valid = 1'b1; l16_i = nl; r16_i = nr;
    end else begin
      in_valid = 1'b0; l16_i = $urandom; r16_i = $urandom;
    end
    cyc = 0; prev_stall = 1'b0; prev_d = 8'd0; prev_last = 1'b0;
    while (got_n < stop_after) begin
      if (cyc >= 100) begin
        timeout_f = 1;
        break;
      end
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ((cyc % 3) == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (cyc == 0) begin
        got_ct = ct_o; got_ct_l = l_ct_o; acc_cyc = cycles;
      end
      ct_pulses += int'(ct_valid);
      l_pulses  += int'(l_ct_valid);
      if (in_ready) in_ready_send++;
      if (prev_stall && (out_data !== prev_d || out_last !== prev_last)) stall_bad++;
      if (out_valid && out_ready) begin
        got_b[got_n] = out_data; got_last[got_n] = out_last;
        got_l[got_n] = l_out_data; got_last_l[got_n] = l_out_last;
        got_n++;
      end
      prev_stall = out_valid && !out_ready; prev_d = out_data; prev_last = out_last;
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({out_valid, out_last, ct_valid, in_ready} !== 4'b0 || out_data !== 8'd0 || ct_o !== 64'd0) begin
      failures++;
      $display("FAIL reset_state: valid=%b last=%b ctv=%b rdy=%b data=%h ct=%h required all 0",
               out_valid, out_last, ct_valid, in_ready, out_data, ct_o);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_kat();
    drive_block(32'h43423234, 32'h0A4CD995, 0, 8, 0, 0, 0);
    checks++;
    if (timeout_f != 0 || acc_ready !== 1'b1) begin
      failures++; $display("FAIL kat_handshake: timeout=%0d acc_ready=%b required 0 1", timeout_f, acc_ready);
    end
    checks++;
    if (got_ct !== kat_ct || got_ct_l !== kat_ct) begin
      failures++; $display("FAIL kat_ct: got %h / %h required %h", got_ct, got_ct_l, kat_ct);
    end
    checks++;
    if (ct_pulses != 1 || l_pulses != 1) begin
      failures++; $display("FAIL kat_ct_valid: pulses %0d/%0d required 1", ct_pulses, l_pulses);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (got_b[k] !== kat_b[k] || got_last[k] !== (k == 7)) begin
        failures++; $display("FAIL kat_byte%0d: got %h last=%b required %h last=%b", k, got_b[k], got_last[k], kat_b[k], (k == 7));
      end
      checks++;
      if (got_l[k] !== kat_b[7 - k] || got_last_l[k] !== (k == 7)) begin
        failures++; $display("FAIL lsb_byte%0d: got %h last=%b required %h", k, got_l[k], got_last_l[k], kat_b[7 - k]);
      end
    end
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || ct_o !== kat_ct || l_ct_o !== 64'd0) begin
      failures++;
      $display("FAIL kat_idle: in_ready=%b out_valid=%b ct=%h lsb_ct=%h required 1 0 %h 0", in_ready, out_valid, ct_o, l_ct_o, kat_ct);
    end
  endtask

  task automatic test_single_bit();
    drive_block(32'h80000000, 32'h0, 0, 8, 0, 0, 0);
    checks++;
    if (got_ct !== 64'h0000000000000080) begin
      failures++; $display("FAIL single_bit_l: got %h required 0000000000000080", got_ct);
    end
    #1 drive_block(32'h0, 32'h80000000, 0, 8, 0, 0, 0);
    checks++;
    if (got_ct !== 64'h0000000000000040) begin
      failures++; $display("FAIL single_bit_r: got %h required 0000000000000040", got_ct);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    #1 drive_block(32'h43423234, 32'h0A4CD995, 1, 8, 0, 0, 0);
    bad = 0;
    for (int k = 0; k < 8; k++) if (got_b[k] !== kat_b[k] || got_last[k] !== (k == 7)) bad++;
    checks++;
    if (bad != 0 || timeout_f != 0) begin
      failures++; $display("FAIL bp_bytes: %0d wrong bytes timeout=%0d required 0 0", bad, timeout_f);
    end
    checks++;
    if (stall_bad != 0 || in_ready_send != 0) begin
      failures++; $display("FAIL bp_stability: unstable=%0d in_ready_in_send=%0d required 0 0", stall_bad, in_ready_send);
    end
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_ready_after_last: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_flush();
    int bad;
    #1 drive_block(32'h43423234, 32'h0A4CD995, 0, 3, 0, 0, 0);
    checks++;
    if (got_b[0] !== 8'h85 || got_b[1] !== 8'hE8 || got_b[2] !== 8'h13) begin
      failures++; $display("FAIL flush_prefix: got %h %h %h required 85 e8 13", got_b[0], got_b[1], got_b[2]);
    end
    flush_i = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h54) begin
      failures++; $display("FAIL flush_hold_byte: valid=%b data=%h required 1 54", out_valid, out_data);
    end
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || in_ready !== 1'b1 || ct_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle: valid=%b last=%b in_ready=%b ctv=%b required 0 0 1 0", out_valid, out_last, in_ready, ct_valid);
    end
    checks++;
    if (ct_o !== kat_ct || l_ct_o !== 64'd0) begin
      failures++; $display("FAIL flush_ct: ct=%h lsb_ct=%h required %h 0", ct_o, l_ct_o, kat_ct);
    end
    drive_block(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 8, 0, 0, 0);
    bad = 0;
    for (int k = 0; k < 8; k++) if (got_b[k] !== 8'hFF || got_last[k] !== (k == 7)) bad++;
    checks++;
    if (got_ct !== 64'hFFFFFFFFFFFFFFFF || bad != 0) begin
      failures++; $display("FAIL flush_next_block: ct=%h bad_bytes=%0d required all ones, 0", got_ct, bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] al, ar, bl, br;
    logic [63:0] a_ct;
    int a_cyc;
    al = $urandom; ar = $urandom; bl = $urandom; br = $urandom;
    #1 drive_block(al, ar, 0, 8, 1, bl, br);
    a_ct = got_ct; a_cyc = acc_cyc;
    checks++;
    if (a_ct !== fp_model(al, ar) || in_ready_send != 0) begin
      failures++; $display("FAIL b2b_first: ct=%h in_ready_in_send=%0d required %h 0", a_ct, in_ready_send, fp_model(al, ar));
    end
    drive_block(bl, br, 0, 8, 0, 0, 0);
    checks++;
    if (got_ct !== fp_model(bl, br) || (acc_cyc - a_cyc) != 9) begin
      failures++;
      $display("FAIL b2b_second: ct=%h spacing=%0d required %h 9", got_ct, acc_cyc - a_cyc, fp_model(bl, br));
    end
  endtask

  task automatic test_random();
    logic [31:0] l, r;
    logic [63:0] exp;
    int bad;
    for (int n = 0; n < 20; n++) begin
      l = $urandom; r = $urandom;
      exp = fp_model(l, r);
      #1 drive_block(l, r, 2, 8, 0, 0, 0);
      bad = 0;
      for (int k = 0; k < 8; k++) begin
        if (got_b[k] !== msb_byte(exp, k) || got_last[k] !== (k == 7)) bad++;
        if (got_l[k] !== lsb_byte(exp, k) || got_last_l[k] !== (k == 7)) bad++;
      end
      checks++;
      if (got_ct !== exp || got_ct_l !== exp || bad != 0 || timeout_f != 0) begin
        failures++;
        $display("FAIL rand%0d: ct=%h lsb_ct=%h bad_bytes=%0d timeout=%0d required %h", n, got_ct, got_ct_l, bad, timeout_f, exp);
      end
      checks++;
      if (stall_bad != 0 || ct_pulses != 1 || in_ready_send != 0 || acc_ready !== 1'b1) begin
        failures++;
        $display("FAIL rand%0d_proto: unstable=%0d pulses=%0d in_ready_in_send=%0d acc_ready=%b required 0 1 0 1",
                 n, stall_bad, ct_pulses, in_ready_send, acc_ready);
      end
    end
  endtask

  task automatic test_async_reset();
    int stale;
    #1 drive_block(32'h43423234, 32'h0A4CD995, 0, 2, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_last, ct_valid, in_ready} !== 4'b0 || out_data !== 8'd0 || ct_o !== 64'd0 ||
        l_out_valid !== 1'b0 || l_ct_o !== 64'd0) begin
      failures++;
      $display("FAIL async_reset: valid=%b last=%b ctv=%b rdy=%b data=%h ct=%h required all 0",
               out_valid, out_last, ct_valid, in_ready, out_data, ct_o);
    end
    out_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL async_release: in_ready=%b required 1", in_ready);
    end
    stale = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1 if (out_valid || l_out_valid) stale++;
    end
    checks++;
    if (stale != 0) begin
      failures++; $display("FAIL async_stale: %0d cycles with out_valid required 0", stale);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; l16_i = 32'd0; r16_i = 32'd0; flush_i = 1'b0; out_ready = 1'b0;
    test_reset();
    test_kat();
    test_single_bit();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
